// File: rtl/ctrl_pkg.sv
// Shared definitions for the back-end control-word pipeline.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ctrl_pkg;

    // Back-end stage indices; stage 0 is where multi-cycle ops are held.
    localparam int STG_EX = 0;
    localparam int STG_ME = 1;
    localparam int STG_WB = 2;

    // Bit offsets of the decoded fields inside the control word.
    localparam int CF_MEMTOREG   = 0;
    localparam int CF_MEMWRITE   = 1;
    localparam int CF_ALUSRC     = 2;
    localparam int CF_REGDST     = 3;
    localparam int CF_REGWRITE   = 4;
    localparam int CF_ALUCONTROL = 5;   // 6 bits: [10:5]
    localparam int CF_ALUCTL_W   = 6;
    localparam int CF_HILOTOREG  = 11;
    localparam int CF_HIORLO     = 12;
    localparam int CF_HIWRITE    = 13;
    localparam int CF_LOWRITE    = 14;

    // EX occupancy FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register holding a control word plus its valid bit.
// Latency: 1 cycle from d to q when loading.
// Backpressure: hold_i keeps contents; flush_i clears and wins over hold; bubble_i loads an empty slot.
module ctrl_stage_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic [W-1:0] ctrl_d_i,
    input  logic         valid_d_i,
    output logic [W-1:0] ctrl_o,
    output logic         valid_o
);

    logic [W-1:0] ctrl_q;
    logic         valid_q;

    // Stage update: reset, then flush, then hold, then bubble or load; invalid words are stored as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            ctrl_q  <= ctrl_q;
            valid_q <= valid_q;
        end else if (bubble_i || !valid_d_i) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d_i;
            valid_q <= 1'b1;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe_mc.sv
// Control-word pipeline from ID through NSTAGE back-end stages, with EX multi-cycle occupancy.
// Latency: word accepted at edge k is on stage j after edge k+j when nothing holds.
// Backpressure: per-stage holds propagate upstream; a held stage sends bubbles downstream; in_ready = ~hold[0].
module ctrl_pipe_mc
    import ctrl_pkg::*;
#(
    parameter int W      = 16,
    parameter int NSTAGE = 3,
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          ctrl_in,
    input  logic                  valid_in,
    input  logic                  mc_in,
    input  logic [NSTAGE-1:0]     stall,
    input  logic [NSTAGE-1:0]     flush,
    output logic [NSTAGE*W-1:0]   ctrl_out,
    output logic [NSTAGE-1:0]     valid_out,
    output logic                  in_ready,
    output logic                  stall_req,
    output logic                  mc_busy
);

    localparam int CNTW = $clog2(MC_LAT + 1);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MC_LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    mc_state_e          state_q;
    logic [CNTW-1:0]    cnt_q;
    logic               mc_hold;
    logic [NSTAGE-1:0]  hold;
    logic               load_ex;
    logic [W-1:0]       stg_ctrl [NSTAGE];
    logic [NSTAGE-1:0]  stg_vld;

    // EX is blocked while an unfinished multi-cycle op still has cycles left.
    assign mc_hold   = (cnt_q != '0);
    assign stall_req = mc_hold;
    assign mc_busy   = (state_q == BUSY);
    assign in_ready  = ~hold[STG_EX];
    assign load_ex   = ~flush[STG_EX] & ~hold[STG_EX];

    // Effective hold chain: each stage holds if it or anything downstream stalls.
    always_comb begin
        logic [NSTAGE-1:0] h_v;
        h_v = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (i == NSTAGE - 1) begin
                h_v[i] = stall[i];
            end else begin
                h_v[i] = stall[i] | h_v[i+1];
            end
        end
        h_v[STG_EX] = h_v[STG_EX] | mc_hold;
        hold = h_v;
    end

    genvar g;
    generate
        for (g = 0; g < NSTAGE; g++) begin : g_stage
            if (g == STG_EX) begin : g_ex
                ctrl_stage_reg #(.W(W)) u_reg (
                    .clk       (clk),
                    .rst       (rst),
                    .flush_i   (flush[g]),
                    .hold_i    (hold[g]),
                    .bubble_i  (1'b0),
                    .ctrl_d_i  (ctrl_in),
                    .valid_d_i (valid_in),
                    .ctrl_o    (stg_ctrl[g]),
                    .valid_o   (stg_vld[g])
                );
            end else begin : g_back
                ctrl_stage_reg #(.W(W)) u_reg (
                    .clk       (clk),
                    .rst       (rst),
                    .flush_i   (flush[g]),
                    .hold_i    (hold[g]),
                    .bubble_i  (hold[g-1]),
                    .ctrl_d_i  (stg_ctrl[g-1]),
                    .valid_d_i (stg_vld[g-1]),
                    .ctrl_o    (stg_ctrl[g]),
                    .valid_o   (stg_vld[g])
                );
            end
            assign ctrl_out[g*W +: W] = stg_ctrl[g];
            assign valid_out[g]       = stg_vld[g];
        end
    endgenerate

    // Occupancy FSM: an accepted mc op arms the counter, which drains one per cycle regardless of stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (flush[STG_EX]) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_ex && valid_in && mc_in && (MC_LAT > 1)) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
